// File: rtl/bool_pipe_if.sv
// Handshake bundle for bool_pipe: producer side (in_*), consumer side (out_*) and occupancy.
interface bool_pipe_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 2
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [1:0]                in_mode;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [LVL_W-1:0]          level;

    // Pipeline side: consumes beats, produces results
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, level
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, level
    );
endinterface

// File: rtl/bool_pipe.sv
// Registered N-input bitwise combiner (PASS/AND/OR/XOR) behind an elastic
// valid/ready pipeline of DEPTH stages with collapsing bubbles.
module bool_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    bool_pipe_if.slave bus
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_AND  = 2'b01,
        MODE_OR   = 2'b10,
        MODE_XOR  = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] result;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];
    logic [LVL_W-1:0] level_q, level_d;
    logic             in_rdy;
    logic             accept;
    logic             emit;

    assign mode = mode_e'(bus.in_mode);

    // Fold all channels into one word according to the mode of the offered beat
    always_comb begin
        result = bus.in_data[WIDTH-1:0];
        for (int unsigned k = 1; k < CHANNELS; k++) begin
            case (mode)
                MODE_AND: result = result & bus.in_data[k*WIDTH +: WIDTH];
                MODE_OR:  result = result | bus.in_data[k*WIDTH +: WIDTH];
                MODE_XOR: result = result ^ bus.in_data[k*WIDTH +: WIDTH];
                default:  result = result;
            endcase
        end
    end

    // Resolve stage advances from the output backwards; the consumer acts as the
    // successor of the last stage, and what is left over decides in_ready
    always_comb begin
        logic succ_frees;
        succ_frees = bus.out_ready;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            adv[DEPTH-1-j] = vld_q[DEPTH-1-j] & succ_frees;
            succ_frees     = ~vld_q[DEPTH-1-j] | adv[DEPTH-1-j];
        end
        in_rdy = succ_frees;
    end

    assign accept = bus.in_valid & in_rdy;
    assign emit   = vld_q[DEPTH-1] & bus.out_ready;

    // Next stage contents and occupancy
    always_comb begin
        vld_d   = vld_q;
        dat_d   = dat_q;
        level_d = level_q;

        if (accept) begin
            vld_d[0] = 1'b1;
            dat_d[0] = result;
        end else if (adv[0]) begin
            vld_d[0] = 1'b0;
        end

        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
                vld_d[i] = 1'b1;
                dat_d[i] = dat_q[i-1];
            end else if (adv[i]) begin
                vld_d[i] = 1'b0;
            end
        end

        if (accept && !emit) begin
            level_d = level_q + LVL_W'(1);
        end else if (!accept && emit) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Stage and occupancy registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            dat_q   <= '{default: '0};
            level_q <= '0;
        end else begin
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            level_q <= level_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_q[DEPTH-1];
    assign bus.out_data  = dat_q[DEPTH-1];
    assign bus.level     = level_q;

endmodule

// File: tb/tb_bool_pipe.sv
// Self-checking bench for bool_pipe. Reference model: an ordered list of beats,
// each with a slot position that creeps toward the output, never passing the beat ahead.
module tb_bool_pipe;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned LVL_W    = $clog2(DEPTH + 1);
    localparam int unsigned VW       = 2 + LVL_W + WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bool_pipe_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus ();

    bool_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               pos;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t mq[$];
    int    acc_log[$];
    int    edge_cnt = 0;
    int    nvec = 0;
    int    nerr = 0;

    // {in_ready, out_valid, level, out_data when valid}
    logic [VW-1:0]    obs_vec, exp_vec;
    logic             obs_acc, obs_emit, obs_ready, obs_valid;
    logic [WIDTH-1:0] obs_data;
    logic [LVL_W-1:0] obs_level;
    int               obs_lat;

    function automatic logic [WIDTH-1:0] ref_comb(input logic [CHANNELS*WIDTH-1:0] d, input logic [1:0] m);
        logic [WIDTH-1:0] r;
        r = d[WIDTH-1:0];
        if (m == 2'b00) return r;
        for (int k = 1; k < int'(CHANNELS); k++) begin
            if (m == 2'b01)      r = r & d[k*WIDTH +: WIDTH];
            else if (m == 2'b10) r = r | d[k*WIDTH +: WIDTH];
            else                 r = r ^ d[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [CHANNELS*WIDTH-1:0] d, input logic [1:0] m, input logic ordy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.out_ready = ordy;
    endtask

    // One clock cycle: capture DUT, predict from model, advance model; returns at negedge
    task automatic step();
        int    limit;
        logic  e_valid, e_emit, e_ready;
        beat_t b;
        #1;
        e_valid = (mq.size() > 0) && (mq[0].pos == int'(DEPTH) - 1);
        e_emit  = e_valid && bus.out_ready;
        limit   = int'(DEPTH);
        for (int i = (e_emit ? 1 : 0); i < mq.size(); i++) begin
            b       = mq[i];
            b.pos   = (b.pos + 1 < limit - 1) ? b.pos + 1 : limit - 1;
            limit   = b.pos;
            mq[i]   = b;
        end
        e_ready = (limit >= 1);
        exp_vec = {e_ready, e_valid, LVL_W'(mq.size()), e_valid ? mq[0].data : {WIDTH{1'b0}}};

        obs_ready = bus.in_ready;
        obs_valid = bus.out_valid;
        obs_level = bus.level;
        obs_data  = bus.out_data;
        obs_vec   = {obs_ready, obs_valid, obs_level, obs_valid ? obs_data : {WIDTH{1'b0}}};
        obs_acc   = bus.in_valid && obs_ready;
        obs_emit  = obs_valid && bus.out_ready;
        obs_lat   = -1;
        if (obs_emit && acc_log.size() > 0) obs_lat = edge_cnt + 1 - acc_log.pop_front();
        if (obs_acc) acc_log.push_back(edge_cnt + 1);

        if (e_emit) void'(mq.pop_front());
        if (bus.in_valid && e_ready) begin
            b.pos  = 0;
            b.data = ref_comb(bus.in_data, bus.in_mode);
            mq.push_back(b);
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 2'b00, 1'b1);
        #2;
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.level !== '0 || bus.out_data !== '0) begin
            nerr++;
            $display("FAIL reset_hold: valid=%b level=%0d data=%h required 0/0/00", bus.out_valid, bus.level, bus.out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // two beats in flight, then reset mid-stream
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'(($urandom)), 2'(($urandom)), 1'b0);
            step();
            nvec++;
            if (obs_vec !== exp_vec) begin
                nerr++;
                $display("FAIL reset_fill[%0d]: got %h required %h", i, obs_vec, exp_vec);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.level !== '0) begin
            nerr++;
            $display("FAIL reset_async: valid=%b level=%0d required 0/0", bus.out_valid, bus.level);
        end
        mq.delete();
        acc_log.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, 2'b00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            nvec++;
            if (obs_vec !== exp_vec || obs_emit !== 1'b0) begin
                nerr++;
                $display("FAIL reset_no_stale[%0d]: got %h emit=%b required %h emit=0", i, obs_vec, obs_emit, exp_vec);
            end
        end
    endtask

    task automatic test_modes();
        logic [WIDTH-1:0] tbl [4];
        bit               got;
        tbl = '{8'hF0, 8'h30, 8'hFC, 8'hCC};
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, {8'h3C, 8'hF0}, 2'(m), 1'b1);
            step();
            drive(1'b0, {8'h3C, 8'hF0}, 2'(m), 1'b1);
            got = 0;
            for (int c = 0; c < 8 && !got; c++) begin
                step();
                nvec++;
                if (obs_vec !== exp_vec) begin
                    nerr++;
                    $display("FAIL modes_vec[m%0d]: got %h required %h", m, obs_vec, exp_vec);
                end
                if (obs_emit) begin
                    got = 1;
                    nvec++;
                    if (obs_data !== tbl[m] || obs_lat != int'(DEPTH)) begin
                        nerr++;
                        $display("FAIL modes_result[m%0d]: got %h lat %0d required %h lat %0d", m, obs_data, obs_lat, tbl[m], DEPTH);
                    end
                end
            end
            if (!got) begin
                nvec++;
                nerr++;
                $display("FAIL modes_timeout[m%0d]: no result, required %h", m, tbl[m]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_emit = 0, first_e = -1, last_e = -1;
        for (int i = 0; i < 14; i++) begin
            if (i < 10) drive(1'b1, 16'(($urandom)), 2'(($urandom)), 1'b1);
            else        drive(1'b0, '0, 2'b00, 1'b1);
            step();
            nvec++;
            if (obs_vec !== exp_vec) begin
                nerr++;
                $display("FAIL b2b_vec[%0d]: got %h required %h", i, obs_vec, exp_vec);
            end
            if (i >= int'(DEPTH) && i < 10) begin
                nvec++;
                if (obs_level !== LVL_W'(DEPTH)) begin
                    nerr++;
                    $display("FAIL b2b_level[%0d]: got %0d required %0d", i, obs_level, DEPTH);
                end
            end
            if (obs_emit) begin
                n_emit++;
                if (first_e < 0) first_e = i;
                last_e = i;
                nvec++;
                if (obs_lat != int'(DEPTH)) begin
                    nerr++;
                    $display("FAIL b2b_latency[%0d]: got %0d required %0d", i, obs_lat, DEPTH);
                end
            end
        end
        nvec++;
        if (n_emit != 10 || last_e - first_e != 9) begin
            nerr++;
            $display("FAIL b2b_count: got %0d results over span %0d required 10 over span 9", n_emit, last_e - first_e);
        end
    endtask

    task automatic test_stall();
        int               n_acc = 0;
        bit               held = 0;
        logic [WIDTH-1:0] held_data = '0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'(($urandom)), 2'(($urandom)), 1'b0);
            step();
            if (obs_acc) n_acc++;
            nvec++;
            if (obs_vec !== exp_vec) begin
                nerr++;
                $display("FAIL stall_vec[%0d]: got %h required %h", i, obs_vec, exp_vec);
            end
            if (held) begin
                nvec++;
                if (obs_valid !== 1'b1 || obs_data !== held_data) begin
                    nerr++;
                    $display("FAIL stall_hold[%0d]: got v=%b %h required v=1 %h", i, obs_valid, obs_data, held_data);
                end
            end else if (obs_valid) begin
                held      = 1;
                held_data = obs_data;
            end
        end
        nvec++;
        if (n_acc != int'(DEPTH) || obs_ready !== 1'b0) begin
            nerr++;
            $display("FAIL stall_accepts: got %0d in_ready=%b required %0d in_ready=0", n_acc, obs_ready, DEPTH);
        end
        drive(1'b0, '0, 2'b00, 1'b1);
        for (int i = 0; i < 10 && mq.size() > 0; i++) begin
            step();
            nvec++;
            if (obs_vec !== exp_vec) begin
                nerr++;
                $display("FAIL stall_drain[%0d]: got %h required %h", i, obs_vec, exp_vec);
            end
        end
        nvec++;
        if (mq.size() != 0) begin
            nerr++;
            $display("FAIL stall_drain_timeout: %0d beats left required 0", mq.size());
        end
    endtask

    task automatic test_bubble();
        drive(1'b1, 16'(($urandom)), 2'b11, 1'b0);
        step();
        drive(1'b0, '0, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) step();
        drive(1'b1, 16'(($urandom)), 2'b10, 1'b0);
        step();
        nvec++;
        if (obs_acc !== 1'b1 || obs_vec !== exp_vec) begin
            nerr++;
            $display("FAIL bubble_accept: got acc=%b %h required acc=1 %h", obs_acc, obs_vec, exp_vec);
        end
        drive(1'b0, '0, 2'b00, 1'b0);
        step();
        nvec++;
        if (obs_level !== LVL_W'(2)) begin
            nerr++;
            $display("FAIL bubble_level: got %0d required 2", obs_level);
        end
        drive(1'b0, '0, 2'b00, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            nvec++;
            if (obs_emit !== 1'b1 || obs_vec !== exp_vec) begin
                nerr++;
                $display("FAIL bubble_release[%0d]: got emit=%b %h required emit=1 %h", i, obs_emit, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_mode_per_beat();
        logic [1:0]       m = 2'b01;
        logic [WIDTH-1:0] next_out = 8'h30;
        for (int i = 0; i < 50; i++) begin
            if (i < 40) drive(1'b1, {8'h3C, 8'hF0}, m, 1'($urandom_range(0, 1)));
            else        drive(1'b0, {8'h3C, 8'hF0}, m, 1'b1);
            step();
            if (obs_acc) m = (m == 2'b01) ? 2'b11 : 2'b01;
            nvec++;
            if (obs_vec !== exp_vec) begin
                nerr++;
                $display("FAIL perbeat_vec[%0d]: got %h required %h", i, obs_vec, exp_vec);
            end
            if (obs_emit) begin
                nvec++;
                if (obs_data !== next_out) begin
                    nerr++;
                    $display("FAIL perbeat_order[%0d]: got %h required %h", i, obs_data, next_out);
                end
                next_out = (next_out == 8'h30) ? 8'hCC : 8'h30;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_stall();
        test_bubble();
        test_mode_per_beat();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
